matrix_stream_tx: RTL and testbench
===================================

# matrix_stream_tx

Streams one result matrix from the unified 400-bit matrix bus as a sequence of 8-bit elements in row-major order, using a valid/ready handshake. It sits downstream of the matrix compute units, including convolution. It captures `out_m`/`out_n`/`matrices_out` when the producer flags `valid`, then feeds the display/UART path one element per accepted beat. It carries position and end-of-row/end-of-matrix flags, and reports how many cycles the transfer took.

## Interface
- Parameters: none. The bus format is fixed: 5x5 slot, 8-bit elements, element (r,c) at bits `[(r*5+c)*8 +: 8]`. Only matrix slot 0 (bits 199:0) is transmitted.
- `clk` in 1: single clock, all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request to capture and send the matrix currently on the bus.
- `src_valid` in 1: producer's `valid`; capture only when `start && src_valid`.
- `src_m` in 3: row count of result, legal 1..5.
- `src_n` in 3: column count of result, legal 1..5.
- `src_bus` in 400: unified matrix bus; bits 399:200 ignored.
- `elem_ready` in 1: sink ready.
- `elem_valid` out 1: element on `elem_data` is valid.
- `elem_data` out 8: current element.
- `elem_row` out 3: row index of current element.
- `elem_col` out 3: column index of current element.
- `elem_eol` out 1: current element is last of its row.
- `elem_last` out 1: current element is last of matrix.
- `busy` out 1: high in SEND and DONE.
- `done` out 1: one-cycle pulse after last handshake.
- `err` out 1: one-cycle pulse on rejected capture (illegal dims).
- `cycleCount` out 10: cycles spent in SEND for the most recent transfer.

## Operation
- FSM states are IDLE, SEND, DONE.
- IDLE:
  - On `start && src_valid`, check dims.
  - Illegal dims (m or n = 0 or > 5): pulse `err` next cycle and stay IDLE. Nothing is latched and `cycleCount` is unchanged.
  - Legal dims: latch m, n and bits 199:0 into an internal 200-bit buffer; clear row/col counters and `cycleCount`; go to SEND.
  - `start` without `src_valid` is ignored.
- SEND:
  - `elem_valid`=1.
  - `elem_data` = buffer element at (row,col).
  - `elem_eol` = (col == n-1).
  - `elem_last` = `elem_eol` && (row == m-1).
  - A handshake is `elem_valid && elem_ready`. On a handshake: if not `elem_eol`, col+1; if `elem_eol`, col 0 and row+1; if `elem_last`, go to DONE.
  - Without a handshake, all elem_* outputs hold.
- DONE: `done`=1 for exactly one cycle, `elem_valid`=0, then return to IDLE.
- `start` is ignored while `busy`. The buffer is immune to bus changes after capture.
- `cycleCount`:
  - Increments every cycle spent in SEND, stalls included.
  - Saturates at 1023.
  - Holds its value in DONE and IDLE until the next legal capture.
- Unused buffer positions (outside m x n) are never output.
- Reset, including mid-transfer: next state IDLE, buffer discarded, counters cleared. No `done` is generated for an aborted transfer.

## Timing
- Reset values are 0 on every output: `elem_valid`, `elem_data`, `elem_row`, `elem_col`, `elem_eol`, `elem_last`, `busy`, `done`, `err`, `cycleCount`.
- All outputs are registered or decoded from registered state. There is no combinational path from `elem_ready` to `elem_valid`. `elem_data` may be a mux of registered buffer and counters.
- Capture at edge k: `busy` and `elem_valid` are high from cycle k+1. The first element is (0,0).
- With `elem_ready` held high: one element per cycle, m*n beats. `done` is asserted the cycle after the `elem_last` handshake, and `cycleCount` = m*n.
- Each stall cycle (ready low in SEND) adds 1 to `cycleCount` and delays `done` by 1.
- `err` is asserted the cycle after the rejected request; `busy` stays 0.
- Back-to-back transfers: a new capture is possible on the first IDLE cycle, i.e. 2 cycles after the last handshake.

## Test plan
- 3x3 matrix with elements 1..9 and ready high:
  - Stream is 1..9.
  - `elem_eol` on beats 3, 6, 9; `elem_last` on beat 9.
  - `done` the next cycle; `cycleCount`=9.
- 2x3 transfer with ready toggling 1,0,1,0...:
  - Data holds during stalls; exactly 6 handshakes.
  - `cycleCount`=11 (6 beats plus 5 stalls).
- Dims m=0 or n=6 with start:
  - `err` pulses once, no `elem_valid`, `cycleCount` unchanged.
- 5x5 transfer:
  - Reset asserted after 7th handshake, then `elem_valid`=0 and all outputs 0 next cycle, no `done`.
  - A new 1x1 transfer then outputs its single element with `elem_eol`=`elem_last`=1 and `cycleCount`=1.
- Start re-asserted and bus changed mid-SEND:
  - Ignored; the original latched values complete unchanged.
- Bits 399:200 set to 0xFF:
  - Never appear on `elem_data`.

Source files
------------

// File: rtl/matrix_stream_tx.sv
// matrix_stream_tx: captures matrix slot 0 from the unified 400-bit bus and
// streams its m x n elements in row-major order over a valid/ready handshake,
// with position and end-of-row/end-of-matrix flags and a SEND cycle counter.
module matrix_stream_tx (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         src_valid,
  input  logic [2:0]   src_m,
  input  logic [2:0]   src_n,
  input  logic [399:0] src_bus,
  input  logic         elem_ready,
  output logic         elem_valid,
  output logic [7:0]   elem_data,
  output logic [2:0]   elem_row,
  output logic [2:0]   elem_col,
  output logic         elem_eol,
  output logic         elem_last,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [9:0]   cycleCount
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;

  logic [199:0]   r_buf;
  logic [2:0]     r_m;
  logic [2:0]     r_n;
  logic [2:0]     r_row;
  logic [2:0]     r_col;
  logic [9:0]     r_cnt;
  logic           r_err;

  logic           w_req;
  logic           w_dims_ok;
  logic           w_capture;
  logic           w_send;
  logic           w_eol;
  logic           w_last;
  logic           w_hs;
  logic [4:0]     w_idx;
  logic [7:0]     w_bitpos;

  // Saturating increment for the SEND cycle counter.
  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == 10'd1023) ? v : v + 10'd1;
  endfunction

  assign w_req     = start && src_valid;
  assign w_dims_ok = (src_m != 3'd0) && (src_m <= 3'd5) &&
                     (src_n != 3'd0) && (src_n <= 3'd5);
  assign w_capture = (r_state == IDLE) && w_req && w_dims_ok;
  assign w_send    = (r_state == SEND);
  assign w_eol     = (r_col == (r_n - 3'd1));
  assign w_last    = w_eol && (r_row == (r_m - 3'd1));
  assign w_hs      = w_send && elem_ready;

  // Element (r,c) lives at byte r*5+c of the 5x5 slot; max index 24 fits 5 bits.
  assign w_idx    = (5'(r_row) * 5'd5) + 5'(r_col);
  assign w_bitpos = {w_idx, 3'b000};

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode: DONE always lasts exactly one cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_capture)       w_state_nxt = SEND;
      SEND:    if (w_hs && w_last)  w_state_nxt = DONE;
      DONE:                         w_state_nxt = IDLE;
      default:                      w_state_nxt = IDLE;
    endcase
  end

  // Capture buffer/dims, walk row/col on handshakes, count SEND cycles, flag rejects.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_buf <= '0;
      r_m   <= '0;
      r_n   <= '0;
      r_row <= '0;
      r_col <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= (r_state == IDLE) && w_req && !w_dims_ok;
      if (w_capture) begin
        r_buf <= src_bus[199:0];
        r_m   <= src_m;
        r_n   <= src_n;
        r_row <= '0;
        r_col <= '0;
        r_cnt <= '0;
      end else if (w_send) begin
        r_cnt <= sat_inc(r_cnt);
        if (elem_ready) begin
          if (w_eol) begin
            r_col <= '0;
            r_row <= r_row + 3'd1;
          end else begin
            r_col <= r_col + 3'd1;
          end
        end
      end
    end
  end

  // Element outputs are only meaningful in SEND; zero elsewhere keeps idle outputs quiet.
  assign elem_valid = w_send;
  assign elem_data  = w_send ? r_buf[w_bitpos +: 8] : 8'd0;
  assign elem_row   = w_send ? r_row : 3'd0;
  assign elem_col   = w_send ? r_col : 3'd0;
  assign elem_eol   = w_send && w_eol;
  assign elem_last  = w_send && w_last;
  assign busy       = (r_state == SEND) || (r_state == DONE);
  assign done       = (r_state == DONE);
  assign err        = r_err;
  assign cycleCount = r_cnt;

endmodule

// File: tb/tb_matrix_stream_tx.sv
// Directed testbench for matrix_stream_tx.
module tb_matrix_stream_tx;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         src_valid;
  logic [2:0]   src_m;
  logic [2:0]   src_n;
  logic [399:0] src_bus;
  logic         elem_ready;
  logic         elem_valid;
  logic [7:0]   elem_data;
  logic [2:0]   elem_row;
  logic [2:0]   elem_col;
  logic         elem_eol;
  logic         elem_last;
  logic         busy;
  logic         done;
  logic         err;
  logic [9:0]   cycleCount;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  matrix_stream_tx dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .src_valid  (src_valid),
    .src_m      (src_m),
    .src_n      (src_n),
    .src_bus    (src_bus),
    .elem_ready (elem_ready),
    .elem_valid (elem_valid),
    .elem_data  (elem_data),
    .elem_row   (elem_row),
    .elem_col   (elem_col),
    .elem_eol   (elem_eol),
    .elem_last  (elem_last),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .cycleCount (cycleCount)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] elem_val(input int base, input int n, input int r, input int c);
    return 8'((base + r * n + c) & 255);
  endfunction

  // Fill slot 0 with base+r*n+c inside m x n, 0xEE outside, and 0xFF in bits 399:200.
  task automatic load_bus(input int m, input int n, input int base);
    src_bus = '1;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        src_bus[(r*5+c)*8 +: 8] = (r < m && c < n) ? elem_val(base, n, r, c) : 8'hEE;
  endtask

  // Request capture at the next edge; returns at the following negedge.
  task automatic capture(input int m, input int n, input int base);
    load_bus(m, n, base);
    src_m = 3'(m); src_n = 3'(n);
    start = 1'b1; src_valid = 1'b1;
    @(negedge clk);
    start = 1'b0; src_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, elem_valid, 0);
    check({tag, "_data"},  elem_data, 0);
    check({tag, "_rowcol"}, {elem_row, elem_col}, 0);
    check({tag, "_flags"}, {elem_eol, elem_last, busy, done, err}, 0);
    check({tag, "_cnt"},   cycleCount, 0);
  endtask

  // Stream a captured matrix; called at the first SEND negedge.
  task automatic stream(input int m, input int n, input int base, input bit toggle,
                        input bit disturb, input int exp_cnt);
    int r = 0, c = 0, hs = 0, cyc = 0;
    bit rdy, fin = 0;
    while (!fin && cyc < 200) begin
      check("valid", elem_valid, 1);
      check("busy", busy, 1);
      check("data", elem_data, elem_val(base, n, r, c));
      check("pos", {elem_row, elem_col}, {3'(r), 3'(c)});
      check("eol", elem_eol, (c == n-1));
      check("last", elem_last, (c == n-1) && (r == m-1));
      if (disturb && cyc == 1) begin
        src_bus = '0; src_m = 3'd1; src_n = 3'd1;
        start = 1'b1; src_valid = 1'b1;
      end
      if (disturb && cyc == 3) begin
        start = 1'b0; src_valid = 1'b0;
      end
      rdy = toggle ? (cyc % 2 == 0) : 1'b1;
      elem_ready = rdy;
      if (rdy) begin
        hs++;
        if (r == m-1 && c == n-1) fin = 1;
        else if (c == n-1) begin c = 0; r++; end
        else c++;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; src_valid = 1'b0;
    check("handshakes", hs, m*n);
    check("done_set", done, 1);
    check("done_busy", busy, 1);
    check("done_valid", elem_valid, 0);
    check("cycle_count", cycleCount, exp_cnt);
    elem_ready = 1'b1;
    @(negedge clk);
    check("done_pulse", done, 0);
    check("idle_busy", busy, 0);
    check("idle_cnt_hold", cycleCount, exp_cnt);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; src_valid = 1'b0;
    src_m = 3'd0; src_n = 3'd0; src_bus = '1; elem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // start without src_valid is ignored
    load_bus(3, 3, 1); src_m = 3'd3; src_n = 3'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("novalid_busy", busy, 0);
    check("novalid_err", err, 0);

    // 3x3, elements 1..9, ready high
    capture(3, 3, 1);
    stream(3, 3, 1, 1'b0, 1'b0, 9);

    // 2x3 with ready toggling, start/bus disturbed mid-SEND
    capture(2, 3, 8'h30);
    stream(2, 3, 8'h30, 1'b1, 1'b1, 11);

    // illegal dims: m=0, then n=6
    capture(0, 3, 0);
    check("err_m0", err, 1);
    check("err_m0_busy", busy, 0);
    check("err_m0_valid", elem_valid, 0);
    @(negedge clk);
    check("err_m0_pulse", err, 0);
    check("err_m0_cnt", cycleCount, 11);
    capture(3, 6, 0);
    check("err_n6", err, 1);
    check("err_n6_valid", elem_valid, 0);
    @(negedge clk);
    check("err_n6_pulse", err, 0);
    check("err_n6_busy", busy, 0);
    check("err_n6_cnt", cycleCount, 11);

    // 5x5 aborted by reset after 7 handshakes
    capture(5, 5, 8'h10);
    elem_ready = 1'b1;
    for (int i = 0; i < 7; i++) @(negedge clk);
    check("abort_pre_data", elem_data, elem_val(8'h10, 5, 1, 2));
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("abort");
    reset = 1'b0;
    @(negedge clk);
    check("abort_no_done", done, 0);
    check("abort_idle_valid", elem_valid, 0);

    // 1x1 after abort; back-to-back 2x2 on first IDLE cycle
    capture(1, 1, 8'h55);
    stream(1, 1, 8'h55, 1'b0, 1'b0, 1);
    capture(2, 2, 8'h60);
    stream(2, 2, 8'h60, 1'b0, 1'b0, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=%0d expected=%0d", 0, 1);
    $fatal(1, "timeout");
  end

endmodule
